// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core constants, fetch FSM states and fetch buffer entry type
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~{{(XLEN - 2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - parameterised synchronous FIFO used for the fetch buffer and the request tag queue
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        empty the FIFO (wins over push/pop)
//   push_i/data_i  write an entry (ignored when full unless popping too)
//   pop_i/data_o   head entry, removed on pop_i (ignored when empty)
//   full_o, empty_o, count_o  occupancy
module fetch_fifo import riscv_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int WIDTH = $bits(fetch_entry_t),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V instruction fetch stage: PC sequencing, imem req/gnt/rvalid, instruction buffer
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   imem_req_o/imem_addr_o/imem_gnt_i request channel (address held until granted)
//   imem_rvalid_i/imem_rdata_i        in-order response channel
//   redirect_i/redirect_pc_i          taken branch/jal/jalr from execute
//   instr_valid_o/instr_o/pc_o        buffer head to decode, instr_ready_i pops
//   fetch_err_o                       misaligned redirect target
// Optional macro IF_MISALIGN_CHECK_EN: misaligned redirect targets enter ERR and raise fetch_err_o;
// otherwise redirect_pc_i[1:0] is ignored and fetch_err_o is tied low.
module instr_fetch_unit import riscv_pkg::*; #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    output logic        fetch_err_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = $bits(fetch_entry_t);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    // Holds off the first request until one cycle after reset release.
    logic            run_en_q, run_en_d;

    logic [CNT_W-1:0] outstanding, buf_count;
    logic             buf_empty, buf_full, tag_empty, tag_full;
    logic [XLEN-1:0]  tag_pc;
    logic [ENT_W-1:0] buf_head_raw;
    fetch_entry_t     buf_head, buf_wdata;
    logic             req, grant, pop, resp_pop, resp_keep, misaligned;
    logic [CNT_W:0]   credit_used, out_next;
    logic [XLEN-1:0]  redirect_target;

    assign buf_head = fetch_entry_t'(buf_head_raw);

    always_comb begin
        pop = !buf_empty && instr_ready_i;
        // Every in-flight request owns a buffer slot. A word leaving the buffer this
        // cycle frees its slot immediately, which is what sustains one fetch per cycle
        // with a two-entry buffer. A request raised this way cannot be retracted: the
        // registered counts already reflect the pop on the next cycle.
        credit_used = {1'b0, outstanding} + {1'b0, buf_count} - (CNT_W + 1)'(pop);
        req = run_en_q && (state_q == ST_RUN) && !tag_full && !(buf_full && !pop)
              && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        grant    = req && imem_gnt_i;
        // The tag queue tracks every issued request, live or stale, so each response pops it.
        resp_pop  = imem_rvalid_i && !tag_empty;
        resp_keep = resp_pop && (discard_q == '0) && !redirect_i;
        out_next  = {1'b0, outstanding} + (CNT_W + 1)'(grant) - (CNT_W + 1)'(resp_pop);
        redirect_target = align_word(redirect_pc_i);
`ifdef IF_MISALIGN_CHECK_EN
        misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        buf_wdata = '{pc: tag_pc, instr: imem_rdata_i};
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        state_d    = state_q;
        run_en_d   = 1'b1;
        if (grant) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (resp_pop && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
        if (redirect_i) begin
            // Everything still in flight after this cycle, including a request
            // granted right now, belongs to the old path.
            fetch_pc_d = redirect_target;
            discard_d  = CNT_W'(out_next);
            if (misaligned) begin
                state_d = ST_ERR;
            end else if (out_next != '0) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end else if ((state_q == ST_FLUSH) && (discard_d == '0)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            run_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            run_en_q   <= run_en_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_instr_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (resp_keep),
        .data_i  (buf_wdata),
        .pop_i   (pop),
        .data_o  (buf_head_raw),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_tag_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (grant),
        .data_i  (fetch_pc_q),
        .pop_i   (resp_pop),
        .data_o  (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (outstanding)
    );

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = !buf_empty;
    assign instr_o       = buf_empty ? NOP_INSTR : buf_head.instr;
    assign pc_o          = buf_empty ? '0 : buf_head.pc;
`ifdef IF_MISALIGN_CHECK_EN
    assign fetch_err_o   = (state_q == ST_ERR);
`else
    assign fetch_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with a transaction-level reference model
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_RUN = 0, M_FLUSH = 1, M_ERR = 2;
`ifdef IF_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        fetch_err_o;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .fetch_err_o   (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus knobs
    bit          k_ready;
    bit          k_redir;
    logic [31:0] k_rpc;
    int          k_gnt_pct;
    int          k_lat_min, k_lat_max;

    // per-cycle samples
    bit          s_valid, s_req, s_err, s_gnt, s_rvalid;
    logic [31:0] s_pc, s_instr, s_addr;

    // memory environment
    typedef struct {logic [31:0] addr; int due;} mr_t;
    mr_t mq[$];

    // reference model: in-flight requests marked live/dead, buffer of delivered words
    typedef struct {logic [31:0] pc; bit dead;} fl_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    fl_t         m_fl[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc;
    int          m_mode;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        bit          e_valid, e_req, pop, granted, mis;
        logic [31:0] e_instr, e_pc;
        int          lat, due;
        fl_t         f;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
        end
        instr_ready_i = k_ready;
        redirect_i    = k_redir;
        redirect_pc_i = k_rpc;
        imem_gnt_i    = ($urandom_range(99) < k_gnt_pct);
        @(negedge clk_i);
        e_valid = (m_buf.size() > 0);
        e_instr = e_valid ? m_buf[0].instr : NOP;
        e_pc    = e_valid ? m_buf[0].pc : 32'h0;
        pop     = e_valid && k_ready;
        e_req   = (m_mode == M_RUN) && ((m_fl.size() + m_buf.size() - int'(pop)) < 2);
        check("valid", 32'(instr_valid_o), 32'(e_valid));
        check("instr", instr_o, e_instr);
        check("pc", pc_o, e_pc);
        check("req", 32'(imem_req_o), 32'(e_req));
        if (e_req) check("addr", imem_addr_o, m_pc);
        check("err", 32'(fetch_err_o), 32'(m_mode == M_ERR));
        s_valid = instr_valid_o; s_pc = pc_o; s_instr = instr_o; s_req = imem_req_o;
        s_addr = imem_addr_o; s_err = fetch_err_o;
        s_gnt = imem_req_o && imem_gnt_i; s_rvalid = imem_rvalid_i;
        // model update for the coming edge
        granted = e_req && imem_gnt_i;
        if (pop) void'(m_buf.pop_front());
        if (imem_rvalid_i && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.dead && !k_redir) m_buf.push_back('{f.pc, imem_rdata_i});
        end
        if (granted) begin
            m_fl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (k_redir) begin
            m_buf.delete();
            foreach (m_fl[i]) m_fl[i].dead = 1'b1;
            mis    = CHK_EN && (k_rpc[1:0] != 2'b00);
            m_pc   = k_rpc & ~32'h3;
            m_mode = mis ? M_ERR : ((m_fl.size() > 0) ? M_FLUSH : M_RUN);
        end else if (m_mode == M_FLUSH && m_fl.size() == 0) begin
            m_mode = M_RUN;
        end
        // memory follows the DUT's actual handshake
        if (imem_rvalid_i) void'(mq.pop_front());
        if (imem_req_o && imem_gnt_i) begin
            lat = $urandom_range(k_lat_max, k_lat_min);
            due = cyc + lat;
            if (mq.size() > 0 && mq[$].due > due) due = mq[$].due;
            mq.push_back('{imem_addr_o, due});
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        k_redir = 1'b0; k_rpc = '0;
        mq.delete(); m_fl.delete(); m_buf.delete();
        m_pc = 32'h0; m_mode = M_RUN;
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, NOP);
        check("rst_pc", pc_o, 32'h0);
        check("rst_err", 32'(fetch_err_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("first_req_delay", 32'(imem_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        cyc = 1;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = s_valid;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        if (found) check(tag, s_pc, exp_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        k_ready = 1'b1; k_gnt_pct = 100; k_lat_min = 1; k_lat_max = 1;

        // 1: streaming, one instruction per cycle from cycle 3
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i >= 3) begin
                check("t1_valid", 32'(s_valid), 32'd1);
                check("t1_pc", s_pc, 32'((i - 3) * 4));
            end else begin
                check("t1_empty", 32'(s_valid), 32'd0);
            end
        end

        // 2: decode stall for 5 cycles
        do_reset();
        k_ready = 1'b0;
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            grants += int'(s_gnt);
        end
        check("t2_grants", 32'(grants), 32'd2);
        check("t2_pc_held", s_pc, 32'h0);
        check("t2_instr_held", s_instr, mem_word(32'h0));
        k_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_release_valid", 32'(s_valid), 32'd1);
            check("t2_release_pc", s_pc, 32'(i * 4));
        end

        // 3: redirect with two requests outstanding
        do_reset();
        k_lat_min = 3; k_lat_max = 3;
        step(); step();
        k_lat_min = 1; k_lat_max = 1;
        k_redir = 1'b1; k_rpc = 32'h0000_0100;
        step();
        check("t3_no_req_full", 32'(s_req), 32'd0);
        k_redir = 1'b0;
        wait_valid("t3_first_pc", 32'h0000_0100);

        // 4: redirect coinciding with grant and response
        do_reset();
        step(); step();
        k_redir = 1'b1; k_rpc = 32'h0000_0040;
        step();
        k_redir = 1'b0;
        check("t4_gnt_in_redirect", 32'(s_gnt), 32'd1);
        check("t4_rvalid_in_redirect", 32'(s_rvalid), 32'd1);
        wait_valid("t4_first_pc", 32'h0000_0040);

        // 5: grant withheld for 3 cycles
        do_reset();
        k_gnt_pct = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_req_held", 32'(s_req), 32'd1);
            check("t5_addr_held", s_addr, 32'h0);
        end
        k_gnt_pct = 100;
        wait_valid("t5_first_pc", 32'h0);

        // PC wrap at the top of the address space
        k_redir = 1'b1; k_rpc = 32'hFFFF_FFF8;
        step();
        k_redir = 1'b0;
        wait_valid("wrap_pc0", 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", s_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", s_pc, 32'h0000_0000);

        // 6: misaligned redirect target
        k_redir = 1'b1; k_rpc = 32'h0000_0102;
        step();
        k_redir = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_err_set", 32'(s_err), 32'd1);
            check("t6_req_off", 32'(s_req), 32'd0);
        end
        k_redir = 1'b1; k_rpc = 32'h0000_0200;
        step();
        k_redir = 1'b0;
        step();
        check("t6_err_clear", 32'(s_err), 32'd0);
        wait_valid("t6_resume_pc", 32'h0000_0200);
`else
        wait_valid("t6_masked_pc", 32'h0000_0100);
        check("t6_err_tied", 32'(s_err), 32'd0);
`endif

        // randomized traffic with an asynchronous reset in the middle
        do_reset();
        k_lat_min = 1; k_lat_max = 3;
        for (int i = 0; i < 700; i++) begin
            if (i == 350) begin
                #2;
                do_reset();
            end
            k_ready   = ($urandom_range(99) < 75);
            k_gnt_pct = 70;
            k_redir   = ($urandom_range(99) < 4);
            k_rpc     = $urandom() & 32'h0000_0FFC;
            if ($urandom_range(7) == 0) k_rpc = k_rpc | 32'(2'($urandom_range(3)));
            if ($urandom_range(9) == 0) k_rpc = k_rpc | 32'hFFFF_F000;
            step();
        end
        k_redir = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core. Sequences the PC, issues in-order requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words in a small FIFO and presents them to decode (whose opcode field drives the control unit). Redirects from branch/jal/jalr resolution flush the buffer and discard in-flight responses.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; also max outstanding requests.

Ports:
- clk_i  in  1  core clock, all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (word aligned).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid (in order, ≥1 cycle after grant).
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  taken branch/jal/jalr from execute.
- redirect_pc_i  in  32  redirect target.
- instr_valid_o  out  1  instr_o/pc_o valid to decode.
- instr_o  out  32  instruction at FIFO head.
- pc_o  out  32  PC of instr_o.
- instr_ready_i  in  1  decode accepts; low = stall.
- fetch_err_o  out  1  misaligned redirect target (IF_MISALIGN_CHECK_EN only, else tied 0).

## Operation

- Registers: fetch_pc, outstanding count (0..FIFO_DEPTH), discard count, FIFO of {pc, instr}, FSM state.
- FSM states: RUN, FLUSH, ERR (ERR only with macro). Reset state RUN.
- RUN: imem_req_o = 1 when outstanding + fifo_count < FIFO_DEPTH; imem_addr_o = fetch_pc. On req && gnt: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), outstanding +1, request PC pushed to a PC tag queue.
- Response: imem_rvalid_i with discard count 0 -> push {tag pc, rdata} into FIFO, outstanding -1. With discard count > 0 -> drop word, discard -1, outstanding -1.
- Decode side: instr_valid_o = FIFO non-empty; pop on instr_valid_o && instr_ready_i. Empty FIFO drives instr_o = 32'h0000_0013 (NOP), pc_o = 0.
- Redirect (any state): fetch_pc <= redirect_pc_i; FIFO flushed; discard count <= outstanding after this cycle's grant/response (a request granted in the redirect cycle is counted as discard; a response arriving that cycle is dropped). Next state FLUSH if discard > 0, else RUN.
- FLUSH: imem_req_o = 0; leave to RUN when discard count reaches 0. Redirect in FLUSH re-loads fetch_pc, stays FLUSH.
- Push and pop in the same cycle both take effect; credit rule makes FIFO overflow impossible.

## Timing

- Reset values: imem_req_o 0, imem_addr_o RESET_PC, instr_valid_o 0, instr_o 32'h0000_0013, pc_o 0, fetch_err_o 0; fetch_pc RESET_PC, counts 0, FIFO empty.
- First imem_req_o one cycle after rst_i deasserts.
- Latency: rvalid in cycle N -> instr_valid_o in cycle N+1 (registered FIFO, no bypass).
- imem_req_o/imem_addr_o stable while req && !gnt (no retraction, address held).
- Redirect in cycle N -> request to redirect_pc_i no earlier than cycle N+1 (N+1 exactly if nothing outstanding).
- Throughput: one instruction/cycle with single-cycle memory and FIFO_DEPTH 2.
- Reset mid-operation clears everything asynchronously; in-flight responses after reset are not tracked (memory is also reset).

## Configuration

- IF_MISALIGN_CHECK_EN defined: redirect with redirect_pc_i[1:0] != 0 enters ERR; fetch_err_o = 1, imem_req_o = 0, FIFO flushed, in-flight responses dropped; only a subsequent aligned redirect (or reset) exits to FLUSH/RUN and clears fetch_err_o.
- Undefined: redirect_pc_i[1:0] ignored (forced to 0), no ERR state, fetch_err_o tied 0.

## Structure

- Shared package riscv_pkg: XLEN = 32, NOP_INSTR = 32'h0000_0013, fetch FSM state enum, fetch entry struct {pc, instr}.
- Sub-module fetch_fifo: parameterised synchronous FIFO (push, pop, flush, full, empty, count) holding fetch entries; instantiated once for the instruction buffer, PC tag queue inline or second instance.

## Test plan

- Reset, memory gnt=1, rvalid 1 cycle later, ready=1 -> PCs 0x0,0x4,0x8... on pc_o, one per cycle from cycle 3.
- instr_ready_i=0 for 5 cycles -> at most 2 requests granted, FIFO holds 0x0/0x4, instr_o stable, no word lost on release.
- Redirect to 0x100 with 2 outstanding -> both responses dropped, next instr_valid_o has pc_o=0x100.
- Redirect in same cycle as grant and rvalid -> granted request discarded, first delivered pc_o = target.
- gnt held low 3 cycles -> imem_addr_o held constant, PC not advanced.
- IF_MISALIGN_CHECK_EN: redirect to 0x102 -> fetch_err_o=1, imem_req_o=0; redirect to 0x200 -> fetch_err_o=0, fetch resumes at 0x200.
